// File: rtl/restoring_divider.sv
// Signed restoring divider: 2W-bit dividend / W-bit divisor.
// Fixed latency, start/busy/done handshake, overflow and /0 flags.
module restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               overflow,
   output logic               div_by_zero
);

   localparam int DW = 2 * WIDTH;
   localparam int CW = $clog2(DW + 1);
   localparam logic [DW-1:0] QPOS = DW'((1 << (WIDTH - 1)) - 1);
   localparam logic [DW-1:0] QNEG = DW'(1 << (WIDTH - 1));

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [CW-1:0]    r_count;
   logic [WIDTH:0]   r_prem;
   logic [DW-1:0]    r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic             r_sgn_q;
   logic             r_sgn_r;
   logic             r_zero;

   logic             r_busy;
   logic             r_done;
   logic             r_ovf;
   logic             r_dz;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;

   logic             w_load;
   logic [DW-1:0]    w_dd_abs;
   logic [WIDTH-1:0] w_dv_abs;
   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_trial;
   logic             w_fit;
   logic [WIDTH:0]   w_prem_nx;
   logic             w_ovf;

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_next = CALC;
               w_load = 1'b1;
            end
         end
         CALC: begin
            if (r_count == CW'(1)) w_next = FIX;
         end
         FIX:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Magnitudes are unsigned, so the most-negative values fit exactly.
   assign w_dd_abs = dividend[DW-1] ? -dividend : dividend;
   assign w_dv_abs = divisor[WIDTH-1] ? -divisor : divisor;

   assign w_shift   = {r_prem, r_quo[DW-1]};
   assign w_trial   = w_shift - {2'b00, r_dvs};
   assign w_fit     = ~w_trial[WIDTH+1];
   assign w_prem_nx = w_fit ? w_trial[WIDTH:0] : w_shift[WIDTH:0];

   assign w_ovf = r_sgn_q ? (r_quo > QNEG) : (r_quo > QPOS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_prem  <= '0;
         r_quo   <= '0;
         r_dvs   <= '0;
         r_sgn_q <= 1'b0;
         r_sgn_r <= 1'b0;
         r_zero  <= 1'b0;
      end else if (w_load) begin
         r_count <= CW'(DW);
         r_prem  <= '0;
         r_quo   <= w_dd_abs;
         r_dvs   <= w_dv_abs;
         r_sgn_q <= dividend[DW-1] ^ divisor[WIDTH-1];
         r_sgn_r <= dividend[DW-1];
         r_zero  <= (divisor == '0);
      end else if (r_state == CALC) begin
         r_count <= r_count - CW'(1);
         r_prem  <= w_prem_nx;
         r_quo   <= {r_quo[DW-2:0], w_fit};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_ovf  <= 1'b0;
         r_dz   <= 1'b0;
         r_q    <= '0;
         r_r    <= '0;
      end else begin
         r_busy <= (w_next != IDLE);
         r_done <= (r_state == FIX);
         if (r_state == FIX) begin
            if (r_zero) begin
               r_q   <= '0;
               r_r   <= '0;
               r_ovf <= 1'b0;
               r_dz  <= 1'b1;
            end else if (w_ovf) begin
               r_q   <= '0;
               r_r   <= '0;
               r_ovf <= 1'b1;
               r_dz  <= 1'b0;
            end else begin
               r_q   <= r_sgn_q ? -r_quo[WIDTH-1:0] : r_quo[WIDTH-1:0];
               r_r   <= r_sgn_r ? -r_prem[WIDTH-1:0] : r_prem[WIDTH-1:0];
               r_ovf <= 1'b0;
               r_dz  <= 1'b0;
            end
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_q;
   assign remainder   = r_r;
   assign overflow    = r_ovf;
   assign div_by_zero = r_dz;

endmodule

// File: tb/tb_restoring_divider.sv
// Bench for restoring_divider: cycle model built from integer division,
// directed cases from the test plan, random and round-trip regressions.
module tb_restoring_divider;

   localparam int W  = 4;
   localparam int DO = 2 * W + 1;

   typedef struct packed {
      logic         ovf;
      logic         dz;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } res_t;

   logic           clk      = 1'b0;
   logic           rst_n    = 1'b1;
   logic           start    = 1'b0;
   logic [2*W-1:0] dividend = '0;
   logic [W-1:0]   divisor  = '0;
   logic           busy;
   logic           done;
   logic [W-1:0]   quotient;
   logic [W-1:0]   remainder;
   logic           overflow;
   logic           div_by_zero;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   function automatic res_t ref_div(input logic [2*W-1:0] dd,
                                    input logic [W-1:0] dv);
      res_t x;
      int a, b, q, r;
      x = '0;
      a = $signed(dd);
      b = $signed(dv);
      if (b == 0) begin
         x.dz = 1'b1;
      end else begin
         q = a / b;
         r = a % b;
         if (q < -(1 << (W - 1)) || q > (1 << (W - 1)) - 1) begin
            x.ovf = 1'b1;
         end else begin
            x.q = q[W-1:0];
            x.r = r[W-1:0];
         end
      end
      return x;
   endfunction

   // Timing model: accept edge A, busy after edges A..A+2W,
   // done after edge A+2W+1, outputs updated on that edge.
   int   m_edge;
   int   m_acc;
   logic m_busy;
   logic m_done;
   res_t m_res;
   res_t m_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_edge <= 0;
         m_acc  <= -1;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_res  <= '0;
         m_pend <= '0;
      end else begin
         m_edge <= m_edge + 1;
         if (!m_busy && start) begin
            m_acc  <= m_edge + 1;
            m_pend <= ref_div(dividend, divisor);
            m_busy <= 1'b1;
            m_done <= 1'b0;
         end else begin
            m_busy <= (m_acc >= 0) && (m_edge + 1 < m_acc + DO);
            m_done <= (m_acc >= 0) && (m_edge + 1 == m_acc + DO);
            if ((m_acc >= 0) && (m_edge + 1 == m_acc + DO))
               m_res <= m_pend;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, want, $time);
      end
   endtask

   task automatic wait_done(input int e0, output int e);
      e = e0;
      while (!done && e < 40) begin
         @(posedge clk);
         e++;
         @(negedge clk);
      end
   endtask

   task automatic run_one(input string nm, input logic [7:0] dd,
                          input logic [3:0] dv, input logic [3:0] eq,
                          input logic [3:0] er, input logic eo,
                          input logic ez);
      int e;
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(1, e);
      chk({nm, "_lat"}, 32'(e), 32'(10));
      chk(nm, 32'({overflow, div_by_zero, quotient, remainder}),
          32'({eo, ez, eq, er}));
   endtask

   task automatic rand_op();
      int q, d, r, ad, n;
      d = int'($urandom_range(0, 15));
      if (d > 7) d -= 16;
      ad = (d < 0) ? -d : d;
      if ($urandom_range(0, 2) == 0 || d == 0) begin
         dividend = 8'($urandom);
      end else begin
         q = int'($urandom_range(0, 15)) - 8;
         r = int'($urandom_range(0, 2 * ad - 2)) - (ad - 1);
         dividend = 8'(q * d + r);
      end
      divisor = 4'(d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n = 1;
      while (!done && n < 40) begin
         if ($urandom_range(0, 3) == 0) begin
            start    = 1'b1;
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk("rand_lat", 32'(n), 32'(10));
   endtask

   task automatic run_all();
      int e, n, k, last, nd;
      logic [7:0] p8;

      #1 rst_n = 1'b0;
      #1 chk("reset", 32'({busy, done, overflow, div_by_zero,
                          quotient, remainder}), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("pin_50_7", 32'(ref_div(8'd50, 4'd7)), 32'(10'b00_0111_0001));
      chk("pin_m50_7", 32'(ref_div(8'hCE, 4'd7)), 32'(10'b00_1001_1111));
      chk("pin_50_m7", 32'(ref_div(8'd50, 4'h9)), 32'(10'b00_1001_0001));
      chk("pin_64_4", 32'(ref_div(8'd64, 4'd4)), 32'(10'b10_0000_0000));
      chk("pin_dz", 32'(ref_div(8'd9, 4'd0)), 32'(10'b01_0000_0000));

      run_one("t50_7", 8'd50, 4'd7, 4'd7, 4'd1, 1'b0, 1'b0);
      run_one("tm50_7", 8'hCE, 4'd7, 4'h9, 4'hF, 1'b0, 1'b0);
      run_one("t50_m7", 8'd50, 4'h9, 4'h9, 4'h1, 1'b0, 1'b0);
      run_one("tm56_m8", 8'hC8, 4'h8, 4'h7, 4'h0, 1'b0, 1'b0);
      run_one("t64_m8", 8'h40, 4'h8, 4'h8, 4'h0, 1'b0, 1'b0);
      run_one("tm32_4", 8'hE0, 4'h4, 4'h8, 4'h0, 1'b0, 1'b0);
      run_one("ovf_64_4", 8'd64, 4'd4, 4'h0, 4'h0, 1'b1, 1'b0);
      run_one("ovf_8_1", 8'd8, 4'd1, 4'h0, 4'h0, 1'b1, 1'b0);
      run_one("ovf_m128_m1", 8'h80, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
      run_one("ovf_m128_m8", 8'h80, 4'h8, 4'h0, 4'h0, 1'b1, 1'b0);
      run_one("t0_5", 8'd0, 4'd5, 4'h0, 4'h0, 1'b0, 1'b0);
      run_one("dz", 8'd77, 4'd0, 4'h0, 4'h0, 1'b0, 1'b1);
      run_one("after_dz", 8'd35, 4'd5, 4'h7, 4'h0, 1'b0, 1'b0);

      dividend = 8'd50;
      divisor  = 4'd7;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      dividend = 8'h9C;
      divisor  = 4'd3;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(4, e);
      chk("ignore_lat", 32'(e), 32'(10));
      chk("ignore_res", 32'({overflow, div_by_zero, quotient, remainder}),
          32'(10'b00_0111_0001));

      dividend = 8'd35;
      divisor  = 4'd5;
      start    = 1'b1;
      n = 0;
      k = 0;
      last = -1;
      while (k < 3 && n < 60) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (done) begin
            if (last >= 0) chk("held_gap", 32'(n - last), 32'(10));
            else           chk("held_first", 32'(n), 32'(10));
            chk("held_q", 32'(quotient), 32'(7));
            last = n;
            k++;
         end
      end
      start = 1'b0;
      chk("held_count", 32'(k), 32'(3));

      run_one("pre_rst", 8'd50, 4'd7, 4'd7, 4'd1, 1'b0, 1'b0);
      dividend = 8'd50;
      divisor  = 4'd7;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1 chk("async_rst", 32'({busy, done, overflow, div_by_zero,
                              quotient, remainder}), 32'(0));
      @(negedge clk);
      @(negedge clk);
      #3 rst_n = 1'b1;
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("no_done", 32'(nd), 32'(0));
      run_one("post_rst", 8'd35, 4'd5, 4'd7, 4'd0, 1'b0, 1'b0);

      repeat (1000) rand_op();

      for (int a = -8; a < 8; a++) begin
         for (int b = -8; b < 8; b++) begin
            if (b != 0) begin
               p8 = 8'(a * b);
               run_one("trip", p8, 4'(b), 4'(a), 4'h0, 1'b0, 1'b0);
            end
         end
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            chk("cycle", 32'({busy, done, overflow, div_by_zero,
                             quotient, remainder}),
                32'({m_busy, m_done, m_res}));
         end
         run_all();
      join_any
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
